// File: rtl/display_source_sequencer_if.sv
// Channel/display bundle between the datapath, the source sequencer and the 7-segment driver.
interface display_source_sequencer_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 16,
  parameter int unsigned OUT_W  = 32
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*CH_W-1:0] ch_data;
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic                   freeze;
  logic [OUT_W-1:0]       ToDisplay;
  logic [SEL_W-1:0]       ch_idx;
  logic                   frozen;

  modport master (
    output ch_data, mode, sel, freeze,
    input  ToDisplay, ch_idx, frozen
  );

  modport slave (
    input  ch_data, mode, sel, freeze,
    output ToDisplay, ch_idx, frozen
  );
endinterface

// File: rtl/display_source_sequencer.sv
// Selects one of NUM_CH channel words (manual index or timed auto rotation, with freeze)
// and registers it zero-extended for the display driver.
module display_source_sequencer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned DWELL  = 100_000_000,
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input logic                          clk,
  input logic                          reset_n,
  display_source_sequencer_if.slave    bus
);

  localparam int unsigned          CNT_W   = $clog2(DWELL);
  localparam logic [CNT_W-1:0]     CntLast = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]     IdxLast = SEL_W'(NUM_CH - 1);

  if (CH_W > OUT_W) begin : g_bad_width
    $error("CH_W must not exceed OUT_W");
  end
  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("NUM_CH must be in 2..16");
  end
  if (DWELL < 2) begin : g_bad_dwell
    $error("DWELL must be at least 2");
  end

  typedef enum logic [1:0] {StManual, StAuto, StHold} state_e;

  state_e           state_q, state_d;
  logic             prev_auto_q, prev_auto_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] disp_q;
  logic             frozen_q;
  logic             load;
  logic [CH_W-1:0]  word;

  always_comb begin
    state_d     = state_q;
    prev_auto_d = prev_auto_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    load        = 1'b1;
    unique case (state_q)
      StManual: begin
        idx_d = bus.sel;
        cnt_d = '0;
        if (bus.freeze) begin
          state_d     = StHold;
          prev_auto_d = 1'b0;
        end else if (bus.mode) begin
          state_d = StAuto;
        end
      end
      StAuto: begin
        // The cycle just shown counts toward the dwell even when leaving for HOLD.
        cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        if (bus.freeze) begin
          state_d     = StHold;
          prev_auto_d = 1'b1;
        end else if (!bus.mode) begin
          state_d = StManual;
          idx_d   = bus.sel;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          idx_d = (idx_q >= IdxLast) ? '0 : idx_q + 1'b1;
        end
      end
      StHold: begin
        if (bus.freeze) begin
          load = 1'b0;
        end else if (!bus.mode) begin
          state_d = StManual;
          idx_d   = bus.sel;
          cnt_d   = '0;
        end else begin
          state_d = StAuto;
          if (!prev_auto_q) begin
            idx_d = bus.sel;
            cnt_d = '0;
          end
        end
      end
      default: state_d = StManual;
    endcase
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (idx_d == SEL_W'(k)) word = bus.ch_data[k*CH_W +: CH_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StManual;
      prev_auto_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      frozen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_auto_q <= prev_auto_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      if (load) disp_q <= OUT_W'(word);
      frozen_q    <= (state_d == StHold);
    end
  end

  assign bus.ToDisplay = disp_q;
  assign bus.ch_idx    = idx_q;
  assign bus.frozen    = frozen_q;

endmodule

// File: tb/tb_display_source_sequencer.sv
// Directed and random checks of two sequencers (4 and 3 channels) against a behavioural model.
module tb_display_source_sequencer;

  localparam int DWELL = 4;
  localparam int ST_M  = 0;
  localparam int ST_A  = 1;
  localparam int ST_H  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        freeze = 1'b0;
  logic [15:0] ch [4];

  int n_cmp = 0;
  int n_fail = 0;

  // Model: one entry per DUT (0: four channels, 1: three channels).
  int          m_st   [2];
  int          m_idx  [2];
  int          m_cnt  [2];
  bit          m_prev [2];
  bit          m_frz  [2];
  logic [31:0] m_disp [2];

  display_source_sequencer_if #(.NUM_CH(4), .CH_W(16), .OUT_W(32)) if4 ();
  display_source_sequencer_if #(.NUM_CH(3), .CH_W(16), .OUT_W(32)) if3 ();

  assign if4.ch_data = {ch[3], ch[2], ch[1], ch[0]};
  assign if4.mode    = mode;
  assign if4.sel     = sel;
  assign if4.freeze  = freeze;
  assign if3.ch_data = {ch[2], ch[1], ch[0]};
  assign if3.mode    = mode;
  assign if3.sel     = sel;
  assign if3.freeze  = freeze;

  display_source_sequencer #(.NUM_CH(4), .CH_W(16), .OUT_W(32), .DWELL(DWELL)) u4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if4)
  );

  display_source_sequencer #(.NUM_CH(3), .CH_W(16), .OUT_W(32), .DWELL(DWELL)) u3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mlook(input int n, input int idx);
    if (idx >= n) return 32'd0;
    return {16'd0, ch[idx]};
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = ST_M; m_idx[d] = 0; m_cnt[d] = 0;
      m_prev[d] = 1'b0; m_frz[d] = 1'b0; m_disp[d] = 32'd0;
    end
  endtask

  // Next model state from the inputs currently applied; call just before the edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int n;
      int to;
      n  = (d == 0) ? 4 : 3;
      to = freeze ? ST_H : (mode ? ST_A : ST_M);
      if (!(m_st[d] == ST_H && to == ST_H)) begin
        if (to == ST_M) begin
          m_idx[d] = int'(sel); m_cnt[d] = 0;
        end else if (to == ST_A) begin
          if (m_st[d] == ST_A) begin
            if (m_cnt[d] == DWELL - 1) begin
              m_cnt[d] = 0;
              m_idx[d] = (m_idx[d] + 1 < n) ? m_idx[d] + 1 : 0;
            end else begin
              m_cnt[d]++;
            end
          end else if (!(m_st[d] == ST_H && m_prev[d])) begin
            m_idx[d] = int'(sel); m_cnt[d] = 0;
          end
        end else if (m_st[d] == ST_M) begin
          m_idx[d] = int'(sel); m_cnt[d] = 0; m_prev[d] = 1'b0;
        end else begin
          m_cnt[d] = (m_cnt[d] + 1) % DWELL; m_prev[d] = 1'b1;
        end
        m_disp[d] = mlook(n, m_idx[d]);
      end
      m_frz[d] = (to == ST_H);
      m_st[d]  = to;
    end
  endtask

  task automatic check_model();
    chk("u4 disp",   if4.ToDisplay,      m_disp[0]);
    chk("u4 idx",    32'(if4.ch_idx),    32'(m_idx[0]));
    chk("u4 frozen", 32'(if4.frozen),    32'(m_frz[0]));
    chk("u3 disp",   if3.ToDisplay,      m_disp[1]);
    chk("u3 idx",    32'(if3.ch_idx),    32'(m_idx[1]));
    chk("u3 frozen", 32'(if3.frozen),    32'(m_frz[1]));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int exp_idx [8];
    exp_idx = '{3, 3, 3, 3, 0, 0, 0, 0};
    ch[0] = 16'hAAAA; ch[1] = 16'hBBBB; ch[2] = 16'hCCCC; ch[3] = 16'hDDDD;

    // 1: reset and manual select
    #12;
    chk("rst disp", if4.ToDisplay, 32'd0);
    chk("rst idx",  32'(if4.ch_idx), 32'd0);
    chk("rst frz",  32'(if4.frozen), 32'd0);
    chk("rst u3 disp", if3.ToDisplay, 32'd0);
    mreset();
    sel = 2'd2;
    reset_n = 1'b1;
    step();
    chk("t1 disp", if4.ToDisplay, 32'h0000CCCC);
    chk("t1 idx",  32'(if4.ch_idx), 32'd2);

    // 2: auto rotation with wrap; also 3-channel out-of-range start
    mode = 1'b1; sel = 2'd3;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2 idx",  32'(if4.ch_idx), 32'(exp_idx[i]));
      chk("t2 disp", if4.ToDisplay, (i < 4) ? 32'h0000DDDD : 32'h0000AAAA);
      if (i == 0) chk("t5 u3 oor disp", if3.ToDisplay, 32'd0);
      if (i == 4) chk("t5 u3 wrap idx", 32'(if3.ch_idx), 32'd0);
    end
    step();
    chk("t2 next idx", 32'(if4.ch_idx), 32'd1);

    // 3: freeze at the second cycle of channel 1
    step();
    freeze = 1'b1;
    step();
    chk("t3 frozen", 32'(if4.frozen), 32'd1);
    chk("t3 disp", if4.ToDisplay, 32'h0000BBBB);
    ch[1] = 16'h1234;
    step();
    step();
    chk("t3 held disp", if4.ToDisplay, 32'h0000BBBB);
    chk("t3 held idx", 32'(if4.ch_idx), 32'd1);
    ch[1] = 16'hBBBB;
    freeze = 1'b0;
    step();
    chk("t3 resume idx", 32'(if4.ch_idx), 32'd1);
    chk("t3 resume frz", 32'(if4.frozen), 32'd0);
    step();
    chk("t3 remain idx", 32'(if4.ch_idx), 32'd1);
    step();
    chk("t3 advance idx", 32'(if4.ch_idx), 32'd2);

    // 4: freeze beats mode change; release to manual; mode drop on wrap cycle
    freeze = 1'b1; mode = 1'b0;
    step();
    chk("t4 frozen", 32'(if4.frozen), 32'd1);
    freeze = 1'b0; sel = 2'd1;
    step();
    chk("t4 manual idx", 32'(if4.ch_idx), 32'd1);
    chk("t4 manual disp", if4.ToDisplay, 32'h0000BBBB);
    mode = 1'b1; sel = 2'd0;
    step();
    step();
    step();
    step();
    mode = 1'b0; sel = 2'd2;
    step();
    chk("t4 wrap->manual idx", 32'(if4.ch_idx), 32'd2);

    // 5: 3-channel manual out of range, then auto wrap to 0
    sel = 2'd3;
    step();
    chk("t5 oor disp", if3.ToDisplay, 32'd0);
    chk("t5 oor idx", 32'(if3.ch_idx), 32'd3);
    mode = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    chk("t5 auto idx", 32'(if3.ch_idx), 32'd0);

    // 6: asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 disp", if4.ToDisplay, 32'd0);
    chk("t6 idx",  32'(if4.ch_idx), 32'd0);
    chk("t6 u3 disp", if3.ToDisplay, 32'd0);
    mreset();
    mode = 1'b0; sel = 2'd1;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    step();
    chk("t6 manual idx", 32'(if4.ch_idx), 32'd1);
    chk("t6 frozen", 32'(if4.frozen), 32'd0);

    // Random phase with sticky mode/freeze so dwell wraps occur.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 6) == 0) freeze = ~freeze;
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 3) == 0) ch[$urandom_range(0, 3)] = 16'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
